// File: rtl/ptp_tx_framer.sv
// ptp_tx_framer
//
// Builds fixed 64-byte PTP-over-Ethernet frames (SYNC and DELAY_RESP) and
// streams them one byte per accepted beat, with a fixed inter-frame gap.
//
// Ports
//   clk            sole clock, rising edge
//   reset          synchronous, active-high
//   timer          local time {ms, cyc}, captured as the SYNC timestamp
//   send_sync_pkt  one-cycle request for a SYNC frame
//   resp_req       one-cycle request for a DELAY_RESP frame
//   resp_ts        DELAY_RESP timestamp, sampled with resp_req
//   resp_seq       DELAY_RESP sequence id, sampled with resp_req
//   tx_data        frame byte
//   tx_valid       tx_data is valid
//   tx_sop         first byte of the frame
//   tx_eop         last byte of the frame
//   tx_ready       sink accepts the byte when tx_valid and tx_ready are both 1
//   ts_1_valid     one-cycle pulse: SYNC departure time captured
//   ts_1           captured SYNC departure time
//   req_drop       one-cycle pulse: request lost, same type already pending
//
// IFG must be at least 1.

module ptp_tx_framer #(
  parameter logic [47:0] SRC_MAC = 48'h00_0A_35_00_00_01,
  parameter logic [47:0] DST_MAC = 48'h01_1B_19_00_00_00,
  parameter int unsigned IFG     = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [47:0] timer,
  input  logic        send_sync_pkt,
  input  logic        resp_req,
  input  logic [47:0] resp_ts,
  input  logic [15:0] resp_seq,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        tx_sop,
  output logic        tx_eop,
  input  logic        tx_ready,
  output logic        ts_1_valid,
  output logic [47:0] ts_1,
  output logic        req_drop
);

  localparam int unsigned     GAP_W    = (IFG > 1) ? $clog2(IFG) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IFG - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t           state;
  state_t           state_next;
  logic [5:0]       byte_idx;
  logic [GAP_W-1:0] gap_cnt;

  logic             sync_pend;
  logic             resp_pend;
  logic [47:0]      resp_ts_q;
  logic [15:0]      resp_seq_q;
  logic [15:0]      sync_seq;

  logic             frame_is_sync;
  logic [15:0]      frame_seq;
  logic [47:0]      frame_ts;
  logic [47:0]      ts_1_q;
  logic             ts_1_valid_q;
  logic             req_drop_q;

  logic             beat;
  logic             last_beat;
  logic             gap_done;
  logic             start;
  logic             start_sync;
  logic             start_resp;
  logic             sync_drop;
  logic             resp_drop;
  logic [191:0]     header;
  logic [7:0]       frame_byte;

  assign beat      = (state == SEND) && tx_ready;
  assign last_beat = beat && (byte_idx == 6'd63);
  assign gap_done  = (state == GAP) && (gap_cnt == GAP_LAST);

  // The last GAP cycle makes the same decision IDLE would, so a pending
  // request starts its frame without an extra idle cycle; this keeps the
  // eop-to-sop distance of back-to-back frames at exactly IFG+1.
  assign start      = ((state == IDLE) || gap_done) && (sync_pend || resp_pend);
  assign start_sync = start && sync_pend;
  assign start_resp = start && !sync_pend;

  // A request is only lost when its flag is set and stays set this cycle.
  assign sync_drop = send_sync_pkt && sync_pend && !start_sync;
  assign resp_drop = resp_req && resp_pend && !start_resp;

  // Next-state decision for the framer.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SEND;
      SEND:    if (last_beat) state_next = GAP;
      GAP:     if (gap_done) state_next = start ? SEND : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register, byte index and gap counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      byte_idx <= '0;
      gap_cnt  <= '0;
    end else begin
      state <= state_next;
      if (last_beat)
        byte_idx <= '0;
      else if (beat)
        byte_idx <= byte_idx + 6'd1;
      if (state == GAP && !gap_done)
        gap_cnt <= gap_cnt + GAP_W'(1);
      else
        gap_cnt <= '0;
    end
  end

  // Pending flags and the DELAY_RESP fields latched with them. A new
  // request wins over the clear, so a request in the very cycle its flag
  // is consumed queues another frame instead of being dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_pend  <= 1'b0;
      resp_pend  <= 1'b0;
      resp_ts_q  <= '0;
      resp_seq_q <= '0;
      req_drop_q <= 1'b0;
    end else begin
      if (send_sync_pkt)
        sync_pend <= 1'b1;
      else if (start_sync)
        sync_pend <= 1'b0;
      if (resp_req)
        resp_pend <= 1'b1;
      else if (start_resp)
        resp_pend <= 1'b0;
      if (resp_req && !resp_drop) begin
        resp_ts_q  <= resp_ts;
        resp_seq_q <= resp_seq;
      end
      req_drop_q <= sync_drop || resp_drop;
    end
  end

  // Per-frame fields are frozen at frame start; the SYNC counter only moves
  // once a SYNC frame has fully left, so an aborted frame never consumes an id.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_is_sync <= 1'b0;
      frame_seq     <= '0;
      frame_ts      <= '0;
      ts_1_q        <= '0;
      ts_1_valid_q  <= 1'b0;
      sync_seq      <= '0;
    end else begin
      ts_1_valid_q <= start_sync;
      if (start_sync) begin
        frame_is_sync <= 1'b1;
        frame_seq     <= sync_seq;
        frame_ts      <= timer;
        ts_1_q        <= timer;
      end else if (start_resp) begin
        frame_is_sync <= 1'b0;
        frame_seq     <= resp_seq_q;
        frame_ts      <= resp_ts_q;
      end
      if (last_beat && frame_is_sync)
        sync_seq <= sync_seq + 16'd1;
    end
  end

  // Bytes 0-23 carry content; everything after is zero padding.
  assign header = {DST_MAC, SRC_MAC, 16'h88F7,
                   (frame_is_sync ? 8'h00 : 8'h09), 8'h02,
                   frame_seq, frame_ts};

  // Byte selection from the header, big-endian.
  always_comb begin
    frame_byte = 8'h00;
    if (byte_idx < 6'd24)
      frame_byte = header[8*(23 - int'(byte_idx)) +: 8];
  end

  // Outputs are forced quiet during reset, including the cycle in which a
  // synchronous reset is first seen mid-frame.
  assign tx_valid   = !reset && (state == SEND);
  assign tx_sop     = tx_valid && (byte_idx == 6'd0);
  assign tx_eop     = tx_valid && (byte_idx == 6'd63);
  assign tx_data    = tx_valid ? frame_byte : 8'h00;
  assign ts_1_valid = !reset && ts_1_valid_q;
  assign ts_1       = reset ? 48'h0 : ts_1_q;
  assign req_drop   = !reset && req_drop_q;

endmodule

// File: tb/tb_ptp_tx_framer.sv
// tb_ptp_tx_framer
//
// Directed bench for ptp_tx_framer. A frame-level model (a queue of expected
// frame descriptors plus a byte-layout function) is checked against the DUT
// on every cycle; a few literal expectations pin the model itself.

module tb_ptp_tx_framer;

  localparam int          IFG = 12;
  localparam logic [47:0] SRC = 48'h00_0A_35_00_00_01;
  localparam logic [47:0] DST = 48'h01_1B_19_00_00_00;

  typedef struct packed {
    logic        is_sync;
    logic [15:0] seq;
    logic [47:0] ts;
  } frame_t;

  logic        clk;
  logic        reset;
  logic [47:0] timer;
  logic        send_sync_pkt;
  logic        resp_req;
  logic [47:0] resp_ts;
  logic [15:0] resp_seq;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_sop;
  logic        tx_eop;
  logic        tx_ready;
  logic        ts_1_valid;
  logic [47:0] ts_1;
  logic        req_drop;

  int checks_total  = 0;
  int checks_passed = 0;

  // Model / monitor state
  frame_t      exp_q[$];
  frame_t      cur;
  bit          in_frame   = 0;
  int          beat       = 0;
  logic [15:0] model_seq  = 16'h0;
  int          cyc        = 0;
  int          frames_done = 0;
  int          last_eop_cyc = 0;
  int          last_sop_cyc = 0;
  int          last_gap   = 0;
  int          drop_count = 0;
  int          ts1_count  = 0;
  logic [15:0] last_seq   = 16'h0;
  logic [7:0]  last_bytes [64];
  bit          exp_ts1v;
  bit          rand_ready = 0;

  logic [7:0] exp36 [10] = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h00,
                             8'h00, 8'h00, 8'h02, 8'h00, 8'h10};
  logic [7:0] exp37 [10] = '{8'h09, 8'h02, 8'h12, 8'h34, 8'hAB,
                             8'hCD, 8'hEF, 8'h01, 8'h23, 8'h45};

  ptp_tx_framer #(.IFG(IFG)) dut (
    .clk           (clk),
    .reset         (reset),
    .timer         (timer),
    .send_sync_pkt (send_sync_pkt),
    .resp_req      (resp_req),
    .resp_ts       (resp_ts),
    .resp_seq      (resp_seq),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_sop        (tx_sop),
    .tx_eop        (tx_eop),
    .tx_ready      (tx_ready),
    .ts_1_valid    (ts_1_valid),
    .ts_1          (ts_1),
    .req_drop      (req_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to measure latencies and gaps.
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks_total++;
    if (actual === expected)
      checks_passed++;
    else
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)",
               name, actual, expected, cyc);
  endtask

  // Expected byte of a frame, straight from the frame layout rules.
  function automatic logic [7:0] modelByte(input frame_t f, input int idx);
    logic [47:0] sh;
    modelByte = 8'h00;
    if (idx < 6) begin
      sh = DST >> (8 * (5 - idx));
      modelByte = sh[7:0];
    end else if (idx < 12) begin
      sh = SRC >> (8 * (11 - idx));
      modelByte = sh[7:0];
    end else if (idx == 12) modelByte = 8'h88;
    else if (idx == 13) modelByte = 8'hF7;
    else if (idx == 14) modelByte = f.is_sync ? 8'h00 : 8'h09;
    else if (idx == 15) modelByte = 8'h02;
    else if (idx == 16) modelByte = f.seq[15:8];
    else if (idx == 17) modelByte = f.seq[7:0];
    else if (idx < 24) begin
      sh = f.ts >> (8 * (23 - idx));
      modelByte = sh[7:0];
    end
  endfunction

  // Compare process: sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      in_frame  = 0;
      model_seq = 16'h0;
      checkOutput("reset_outputs",
                  64'({tx_valid, tx_sop, tx_eop, ts_1_valid, req_drop, tx_data, ts_1}),
                  64'h0);
    end else begin
      exp_ts1v = 0;
      if (req_drop) drop_count++;
      if (ts_1_valid) ts1_count++;
      if (tx_valid && !in_frame) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_frame", 64'(tx_valid), 64'h0);
        end else begin
          cur = exp_q.pop_front();
          if (cur.is_sync) begin
            cur.seq  = model_seq;
            exp_ts1v = 1;
          end
          in_frame     = 1;
          beat         = 0;
          last_gap     = cyc - last_eop_cyc;
          last_sop_cyc = cyc;
        end
      end
      checkOutput("ts_1_valid", 64'(ts_1_valid), 64'(exp_ts1v));
      if (exp_ts1v) checkOutput("ts_1", 64'(ts_1), 64'(cur.ts));
      if (in_frame) begin
        if (!tx_valid) begin
          checkOutput("valid_held", 64'(tx_valid), 64'h1);
          in_frame = 0;
        end else begin
          checkOutput("tx_data", 64'(tx_data), 64'(modelByte(cur, beat)));
          checkOutput("tx_sop", 64'(tx_sop), 64'(beat == 0));
          checkOutput("tx_eop", 64'(tx_eop), 64'(beat == 63));
          if (tx_ready) begin
            last_bytes[beat] = tx_data;
            beat++;
            if (beat == 64) begin
              in_frame     = 0;
              frames_done++;
              last_eop_cyc = cyc;
              last_seq     = cur.seq;
              if (cur.is_sync) model_seq = model_seq + 16'h1;
            end
          end
        end
      end
    end
  end

  // Sink readiness: always ready, or a coin flip per cycle when enabled.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle request pulse; called just after a rising edge.
  task automatic applyStimulus(input bit sync, input bit resp,
                               input logic [15:0] seq, input logic [47:0] ts);
    send_sync_pkt = sync;
    resp_req      = resp;
    resp_seq      = seq;
    resp_ts       = ts;
    tick(1);
    send_sync_pkt = 1'b0;
    resp_req      = 1'b0;
  endtask

  task automatic waitFrames(input int target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin
      tick(1);
      n++;
    end
    checkOutput("frames_done", 64'(frames_done), 64'(target));
  endtask

  function automatic frame_t mkFrame(input bit s, input logic [15:0] q,
                                     input logic [47:0] t);
    frame_t f;
    f.is_sync = s;
    f.seq     = q;
    f.ts      = t;
    return f;
  endfunction

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int req_cyc;
    int base;
    int drops0;
    int n;
    reset         = 1'b1;
    timer         = 48'h0;
    send_sync_pkt = 1'b0;
    resp_req      = 1'b0;
    resp_ts       = 48'h0;
    resp_seq      = 16'h0;
    tick(3);
    reset = 1'b0;
    tick(2);
    checkOutput("idle_valid", 64'(tx_valid), 64'h0);

    // SYNC frame with a known timer value.
    $display("[TB] SYNC frame");
    timer = 48'h0000_0002_0010;
    exp_q.push_back(mkFrame(1, 16'h0, timer));
    req_cyc = cyc;
    applyStimulus(1, 0, 16'h0, 48'h0);
    waitFrames(1, 200);
    checkOutput("sop_latency", 64'(last_sop_cyc - req_cyc), 64'd2);
    for (int i = 0; i < 10; i++)
      checkOutput("sync_bytes14_23", 64'(last_bytes[14 + i]), 64'(exp36[i]));
    checkOutput("ts1_pulses", 64'(ts1_count), 64'd1);
    checkOutput("first_seq", 64'(last_seq), 64'h0);
    tick(IFG + 2);

    // DELAY_RESP frame.
    $display("[TB] DELAY_RESP frame");
    exp_q.push_back(mkFrame(0, 16'h1234, 48'hABCD_EF01_2345));
    applyStimulus(0, 1, 16'h1234, 48'hABCD_EF01_2345);
    waitFrames(2, 200);
    for (int i = 0; i < 10; i++)
      checkOutput("resp_bytes14_23", 64'(last_bytes[14 + i]), 64'(exp37[i]));
    tick(IFG + 2);

    // Both requests together: SYNC first, then DELAY_RESP after IFG.
    $display("[TB] simultaneous requests");
    timer = 48'h0000_0005_1234;
    exp_q.push_back(mkFrame(1, 16'h0, timer));
    exp_q.push_back(mkFrame(0, 16'h0042, 48'h1111_2222_3333));
    applyStimulus(1, 1, 16'h0042, 48'h1111_2222_3333);
    waitFrames(4, 400);
    checkOutput("b2b_gap", 64'(last_gap), 64'(IFG + 1));
    checkOutput("resp_after_sync", 64'(last_seq), 64'h0042);
    tick(IFG + 2);

    // Random back-pressure.
    $display("[TB] random tx_ready");
    rand_ready = 1;
    timer = 48'h0000_0007_0001;
    exp_q.push_back(mkFrame(1, 16'h0, timer));
    exp_q.push_back(mkFrame(0, 16'hBEEF, 48'h0102_0304_0506));
    applyStimulus(1, 1, 16'hBEEF, 48'h0102_0304_0506);
    waitFrames(6, 3000);
    rand_ready = 0;
    tick(IFG + 2);

    // Requests during SEND: one of each queued, one of each dropped.
    $display("[TB] drops");
    drops0 = drop_count;
    timer = 48'h0000_0009_0009;
    exp_q.push_back(mkFrame(1, 16'h0, timer));
    exp_q.push_back(mkFrame(1, 16'h0, timer));
    exp_q.push_back(mkFrame(0, 16'h5555, 48'hAAAA_0000_0001));
    applyStimulus(1, 0, 16'h0, 48'h0);
    tick(10);
    applyStimulus(1, 0, 16'h0, 48'h0);
    applyStimulus(1, 0, 16'h0, 48'h0);
    applyStimulus(0, 1, 16'h5555, 48'hAAAA_0000_0001);
    applyStimulus(0, 1, 16'h6666, 48'hBBBB_0000_0002);
    waitFrames(9, 600);
    checkOutput("drop_pulses", 64'(drop_count - drops0), 64'd2);
    checkOutput("latched_seq_kept", 64'(last_seq), 64'h5555);
    tick(IFG + 2);

    // Sequence counter wrap.
    $display("[TB] seq wrap");
    force dut.sync_seq = 16'hFFFF;
    model_seq = 16'hFFFF;
    tick(1);
    release dut.sync_seq;
    exp_q.push_back(mkFrame(1, 16'h0, timer));
    applyStimulus(1, 0, 16'h0, 48'h0);
    waitFrames(10, 200);
    checkOutput("seq_ffff", 64'(last_seq), 64'hFFFF);
    tick(IFG + 2);
    exp_q.push_back(mkFrame(1, 16'h0, timer));
    applyStimulus(1, 0, 16'h0, 48'h0);
    waitFrames(11, 200);
    checkOutput("seq_wrap", 64'(last_seq), 64'h0000);
    tick(IFG + 2);

    // Reset mid-frame.
    $display("[TB] reset mid-frame");
    exp_q.push_back(mkFrame(1, 16'h0, timer));
    applyStimulus(1, 0, 16'h0, 48'h0);
    n = 0;
    while (!(in_frame && beat == 30) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reached_byte30", 64'(beat), 64'd30);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abort_valid", 64'(tx_valid), 64'h0);
    checkOutput("abort_queue", 64'(exp_q.size()), 64'h0);
    base = frames_done;
    tick(2);
    exp_q.push_back(mkFrame(1, 16'h0, timer));
    applyStimulus(1, 0, 16'h0, 48'h0);
    waitFrames(base + 1, 200);
    checkOutput("seq_after_abort", 64'(last_seq), 64'h0);
    tick(IFG + 2);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/ptp_tx_framer.md
PTP_TX_FRAMER -- requirements
Module: ptp_tx_framer

Interface
REQ-001 Parameter SRC_MAC, default 48'h00_0A_35_00_00_01, source MAC placed in every frame.
REQ-002 Parameter DST_MAC, default 48'h01_1B_19_00_00_00, destination MAC placed in every frame.
REQ-003 Parameter IFG, default 12, idle cycles after each frame's last byte.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 timer  input  48  local time {ms[47:17], cyc[16:0]}, cyc in 0..124999.
REQ-007 send_sync_pkt  input  1  one-cycle request to send a SYNC frame.
REQ-008 resp_req  input  1  one-cycle request to send a DELAY_RESP frame.
REQ-009 resp_ts  input  48  timestamp carried by DELAY_RESP; sampled when resp_req=1.
REQ-010 resp_seq  input  16  sequence id for DELAY_RESP; sampled when resp_req=1.
REQ-011 tx_data  output  8  frame byte.
REQ-012 tx_valid  output  1  tx_data is valid.
REQ-013 tx_sop / tx_eop  output  1 each  first / last byte of frame.
REQ-014 tx_ready  input  1  sink accepts the byte when tx_valid and tx_ready are both 1.
REQ-015 ts_1_valid  output  1  one-cycle pulse: SYNC departure time captured.
REQ-016 ts_1  output  48  captured SYNC departure time.
REQ-017 req_drop  output  1  one-cycle pulse: request lost because one of the same type was already pending.

Function
REQ-018 Pending flags: sync_pend is set by send_sync_pkt; resp_pend is set by resp_req, which also latches resp_ts and resp_seq.
REQ-019 A request arriving while its flag is already set, and not being cleared that cycle, is dropped, pulses req_drop, and leaves the latched values unchanged.
REQ-020 FSM states are IDLE, SEND and GAP.
REQ-021 IDLE -> SEND when any flag is set; SYNC wins if both flags are set; the chosen flag clears on that transition.
REQ-022 On IDLE->SEND for SYNC, the current timer value is captured into the frame timestamp and ts_1, and ts_1_valid pulses the following cycle.
REQ-023 Frame length is 64 bytes; a byte index 0..63 advances only on a tx_valid&tx_ready beat.
REQ-024 Byte layout, big-endian: 0-5 DST_MAC; 6-11 SRC_MAC; 12-13 0x88F7; 14 msg type (0x00 SYNC, 0x09 DELAY_RESP); 15 0x02; 16-17 seq id; 18-23 48-bit timestamp; 24-63 0x00.
REQ-025 SYNC seq id comes from an internal 16-bit counter; the counter increments after each SYNC frame's byte 63 beat and wraps 0xFFFF->0x0000.
REQ-026 DELAY_RESP uses the latched resp_seq and resp_ts.
REQ-027 In SEND, tx_valid=1 continuously; tx_data, tx_sop and tx_eop hold stable while tx_ready=0.
REQ-028 tx_sop=1 only at index 0; tx_eop=1 only at index 63.
REQ-029 SEND -> GAP on the index-63 beat; GAP lasts IFG cycles with tx_valid=0, then returns to IDLE.
REQ-030 A request arriving during SEND or GAP is queued via its flag and served after GAP.
REQ-031 Back-to-back throughput: a new frame's byte 0 is presented exactly IFG+1 cycles after the previous eop beat.
REQ-032 First byte of a frame appears the cycle after IDLE->SEND, so sop is presented 2 cycles after the request.

Reset
REQ-033 While reset=1: state=IDLE, both flags cleared, seq counter=0, byte index=0, latched values cleared.
REQ-034 While reset=1: tx_valid, tx_sop, tx_eop, ts_1_valid and req_drop are 0; tx_data=0 and ts_1=0.
REQ-035 Reset asserted mid-frame aborts the frame immediately with no eop and no seq increment.

Verification
REQ-036 tx_ready=1, timer=48'h0000_0002_0010, send_sync_pkt pulse -> sop 2 cycles later; bytes 14-23 = 00 02 00 00 00 00 00 02 00 10; ts_1_valid pulses once.
REQ-037 resp_req with resp_seq=0x1234, resp_ts=48'hABCDEF012345 -> byte 14 = 0x09, bytes 16-17 = 12 34, bytes 18-23 = AB CD EF 01 23 45.
REQ-038 send_sync_pkt and resp_req in the same cycle -> SYNC frame first, then exactly IFG idle cycles, then the DELAY_RESP frame.
REQ-039 tx_ready toggling pseudo-randomly -> every byte held stable until accepted; exactly 64 accepted beats per frame.
REQ-040 Second send_sync_pkt while sync_pend=1 -> req_drop pulses once; seq counter preset to 0xFFFF -> next seq is 0x0000.
REQ-041 Reset asserted at byte 30 -> tx_valid=0 the next cycle; the following SYNC frame reuses the unincremented seq id.
